// File: rtl/uio_arbiter.sv
// uio_arbiter: round-robin arbiter handing the shared 8-bit bidirectional
// uio pin bank to one of N_REQ requesters at a time.
//
// A tenure is IDLE -> TURN -> GRANT. TURN is a one-cycle bus turnaround with
// the pins tri-stated, and GRANT lasts at most TIMEOUT cycles. The gnt output
// is a flop. The pin outputs are decoded from the registered state and the
// winner index, so an asynchronous reset releases the pins immediately.
// Direction and drive data of the winner pass through combinationally while
// it holds the bus.

module uio_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     rel,
    input  logic [N_REQ-1:0]     dir,
    input  logic [8*N_REQ-1:0]   dout,
    output logic [N_REQ-1:0]     gnt,
    output logic [7:0]           uio_out,
    output logic [7:0]           uio_oe,
    output logic                 busy,
    output logic                 timeout
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   w_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_REQ-1:0]   gnt_q;
    logic               timeout_q;

    logic [PTR_W-1:0]   w_d;
    logic               w_found;
    logic [PTR_W-1:0]   rr_idx;
    logic [PTR_W-1:0]   ptr_d;
    logic [7:0]         dout_w;
    logic               in_grant;
    logic               rel_w;
    logic               req_w;
    logic               cnt_hit;
    logic               grant_exit;
    logic               timeout_exit;

    // Round-robin search starting at ptr_q, first requester found wins.
    always_comb begin
        w_d     = '0;
        w_found = 1'b0;
        rr_idx  = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            rr_idx = PTR_W'((32'(ptr_q) + off) % N_REQ);
            if (!w_found && req[rr_idx]) begin
                w_found = 1'b1;
                w_d     = rr_idx;
            end
        end
    end

    // Winner's drive byte, selected from the packed dout bus.
    always_comb begin
        dout_w = 8'h00;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_q == PTR_W'(i)) begin
                dout_w = dout[8*i +: 8];
            end
        end
    end

    // Tenure exit conditions; a release wins over a coincident timeout.
    always_comb begin
        rel_w        = rel[w_q];
        req_w        = req[w_q];
        cnt_hit      = (cnt_q == CNT_LAST);
        grant_exit   = rel_w || !req_w || !ena || cnt_hit;
        timeout_exit = cnt_hit && !rel_w && req_w && ena;
        ptr_d        = (w_q == PTR_LAST) ? '0 : w_q + PTR_W'(1);
    end

    // Arbitration FSM with tenure counter, rotating pointer and grant flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            w_q       <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ena && w_found) begin
                        w_q     <= w_d;
                        state_q <= TURN;
                    end
                end
                TURN: begin
                    cnt_q   <= '0;
                    gnt_q   <= N_REQ'(1) << w_q;
                    state_q <= GRANT;
                end
                GRANT: begin
                    if (grant_exit) begin
                        state_q   <= IDLE;
                        gnt_q     <= '0;
                        ptr_q     <= ptr_d;
                        timeout_q <= timeout_exit;
                    end else if (cnt_q != CNT_LAST) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    // Pin drivers decoded from the registered state; tri-stated outside GRANT.
    always_comb begin
        in_grant = (state_q == GRANT);
        uio_oe   = (in_grant && dir[w_q]) ? 8'hFF : 8'h00;
        uio_out  = (in_grant && dir[w_q]) ? dout_w : 8'h00;
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q != IDLE);
    assign timeout = timeout_q;

endmodule
